// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART frame serialiser. Each frame is a start bit (0), DATA_WIDTH data bits
// sent LSB first, an optional parity bit, and a stop bit (1). Every bit is held for PRESCALE
// clock cycles.
//
// Ports:
//   CLK        clock
//   RST        synchronous reset, active-high
//   P_DATA     word to transmit, latched on the accept edge
//   DATA_VALID request strobe, accepted only while idle
//   PAR_EN     1 = append a parity bit
//   PAR_TYP    0 = even parity, 1 = odd parity
//   PRESCALE   clock cycles per serial bit (0 is treated as 1)
//   TX_OUT     registered serial line, idles high
//   BUSY       registered, high from the accept edge until the frame ends
//
// Build option: define UART_TX_STOP2_EN to send two stop bits per frame.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] period_q, period_d;
  logic [BitW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [DATA_WIDTH-1:0]     shift_nxt;
  logic                      par_en_q, par_en_d;
  logic                      parity_q, parity_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      period_end;
  logic                      stop_done;

  // period_q is forced non-zero on accept, so the subtraction cannot wrap while framing.
  assign period_end = (cnt_q == period_q - PRESCALE_WIDTH'(1));
  assign shift_nxt  = shift_q >> 1;

  // In STOP the bit counter is reused to count stop bits.
`ifdef UART_TX_STOP2_EN
  assign stop_done = (bit_q != '0);
`else
  assign stop_done = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_en_d = par_en_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    busy_d   = busy_q;

    if (state_q != StIdle) begin
      cnt_d = period_end ? '0 : cnt_q + PRESCALE_WIDTH'(1);
    end

    // tx_d always carries the level of the bit being entered, so TX_OUT is a pure flop.
    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        bit_d  = '0;
        if (DATA_VALID) begin
          shift_d  = P_DATA;
          par_en_d = PAR_EN;
          parity_d = PAR_TYP ^ (^P_DATA);
          period_d = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
          state_d  = StStart;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      StStart: begin
        if (period_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (period_end) begin
          if (bit_q == LastBit) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = parity_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BitW'(1);
            shift_d = shift_nxt;
            tx_d    = shift_nxt[0];
          end
        end
      end
      StParity: begin
        if (period_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (period_end) begin
          if (stop_done) begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            bit_d   = '0;
          end else begin
            bit_d = BitW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_en_q <= par_en_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: self-checking bench for uart_tx_frame. A queue-based frame model predicts
// TX_OUT/BUSY every cycle; directed scenarios add literal expectations on top.
module tb_uart_tx_frame;

`ifdef UART_TX_STOP2_EN
  localparam int StopBits = 2;
`else
  localparam int StopBits = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] PRESCALE = '0;
  logic       TX_OUT;
  logic       BUSY;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic exp_q[$];
  logic rec_tx[0:127];
  logic rec_busy[0:127];

  uart_tx_frame #(
    .DATA_WIDTH    (8),
    .PRESCALE_WIDTH(6)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .PRESCALE  (PRESCALE),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Line levels, one entry per clock cycle, for a whole frame.
  task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] pre);
    int p;
    logic bits[$];
    p = (pre == 0) ? 1 : int'(pre);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pt ^ (^d));
    for (int i = 0; i < StopBits; i++) bits.push_back(1'b1);
    foreach (bits[k]) for (int j = 0; j < p; j++) exp_q.push_back(bits[k]);
  endtask

  always @(posedge CLK) begin
    if (RST) exp_q.delete();
    else if (exp_q.size() != 0) void'(exp_q.pop_front());
    else if (DATA_VALID) build_frame(P_DATA, PAR_EN, PAR_TYP, PRESCALE);
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_tx", int'(TX_OUT), (exp_q.size() != 0) ? int'(exp_q[0]) : 1);
      check("model_busy", int'(BUSY), (exp_q.size() != 0) ? 1 : 0);
    end
  end

  // Called at a negedge; leaves the bench at the negedge showing the start bit.
  task automatic start(input logic [7:0] d, input logic [5:0] p, input logic pe,
                       input logic pt, input bit hold);
    P_DATA = d;
    PRESCALE = p;
    PAR_EN = pe;
    PAR_TYP = pt;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    if (!hold) DATA_VALID = 1'b0;
  endtask

  task automatic capture(input int n, input bit disturb);
    for (int i = 0; i < n; i++) begin
      rec_tx[i] = TX_OUT;
      rec_busy[i] = BUSY;
      if (disturb && i == 20) begin
        DATA_VALID = 1'b1;
        P_DATA = 8'hC4;
        PRESCALE = 6'd3;
      end
      if (disturb && i == 21) DATA_VALID = 1'b0;
      @(negedge CLK);
    end
  endtask

  function automatic int busy_count(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(rec_busy[i]);
    return c;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("idle_timeout", int'(BUSY), 0);
    @(negedge CLK);
  endtask

  initial begin
    logic [9:0] seq1;
    logic [7:0] d;
    int len;

    repeat (3) @(negedge CLK);
    check("reset_tx", int'(TX_OUT), 1);
    check("reset_busy", int'(BUSY), 0);
    RST = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);

    // Scenario 1: A5 at one cycle per bit.
    seq1 = 10'b1101001010;
    start(8'hA5, 6'd1, 1'b0, 1'b0, 1'b0);
    capture(16, 1'b0);
    for (int i = 0; i < 10; i++) check("s1_seq", int'(rec_tx[i]), int'(seq1[i]));
    check("s1_busy_len", busy_count(16), 9 + StopBits);
    for (int i = 10; i < 16; i++) check("s1_idle_high", int'(rec_tx[i]), 1);
    wait_idle();

    // Scenarios 2 and 3: even then odd parity, with inputs disturbed mid-frame.
    for (int t = 0; t < 2; t++) begin
      d = 8'h03;
      start(d, 6'd8, 1'b1, t[0], 1'b0);
      capture(110, 1'b1);
      check("s2_busy_len", busy_count(110), (10 + StopBits) * 8);
      for (int k = 0; k < 8; k++) check("s3_data_bit", int'(rec_tx[8 + 8 * k + 4]), int'(d[k]));
      check("s2_parity_first", int'(rec_tx[72]), t);
      check("s2_parity_last", int'(rec_tx[79]), t);
      check("s3_no_second", int'(rec_busy[(10 + StopBits) * 8 + 2]), 0);
      wait_idle();
    end

    // Scenario 4: DATA_VALID held high gives back-to-back frames with a 1-cycle gap.
    len = (10 + StopBits) * 4;
    start(8'hFF, 6'd4, 1'b1, 1'b1, 1'b1);
    capture(2 * len + 4, 1'b0);
    DATA_VALID = 1'b0;
    check("s4_busy_end", int'(rec_busy[len - 1]), 1);
    check("s4_gap_busy", int'(rec_busy[len]), 0);
    check("s4_gap_tx", int'(rec_tx[len]), 1);
    check("s4_next_busy", int'(rec_busy[len + 1]), 1);
    check("s4_next_start", int'(rec_tx[len + 1]), 0);
    check("s4_parity1", int'(rec_tx[36]), 1);
    check("s4_parity2", int'(rec_tx[len + 1 + 36]), 1);
    wait_idle();

    // Scenario 5: reset during data bit 3, then a clean frame.
    start(8'h00, 6'd2, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge CLK);
    check("s5_in_frame", int'(BUSY), 1);
    RST = 1'b1;
    @(negedge CLK);
    check("s5_rst_tx", int'(TX_OUT), 1);
    check("s5_rst_busy", int'(BUSY), 0);
    RST = 1'b0;
    @(negedge CLK);
    d = 8'($urandom);
    start(d, 6'd1, 1'b0, 1'b0, 1'b0);
    capture(14, 1'b0);
    check("s5_start_bit", int'(rec_tx[0]), 0);
    for (int k = 0; k < 8; k++) check("s5_data_bit", int'(rec_tx[1 + k]), int'(d[k]));
    check("s5_busy_len", busy_count(14), 9 + StopBits);
    wait_idle();

    // Scenario 6: PRESCALE=0 behaves as 1.
    d = 8'h5A;
    start(d, 6'd0, 1'b0, 1'b0, 1'b0);
    capture(14, 1'b0);
    for (int k = 0; k < 8; k++) check("s6_data_bit", int'(rec_tx[1 + k]), int'(d[k]));
    check("s6_busy_len", busy_count(14), 9 + StopBits);
    for (int s = 0; s < StopBits; s++) check("s6_stop", int'(rec_tx[9 + s]), 1);
    wait_idle();

    // Random traffic, including mid-frame input churn and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      DATA_VALID = ($urandom_range(0, 3) == 0);
      P_DATA = 8'($urandom);
      PRESCALE = 6'($urandom_range(0, 5));
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
      RST = ($urandom_range(0, 399) == 0);
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    RST = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
